// File: rtl/bcd_feeder.sv
// bcd_feeder: 27-bit binary to 8-digit BCD via iterative double-dabble, then
// eight (dig, pos) display writes. Optional macro SAT_EN saturates display to 99999999 on overflow.
module bcd_feeder (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] value,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  dig,
  output logic [3:0]  pos
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [26:0] shreg_q, shreg_d;
  logic [35:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        ovf_q, ovf_d;

  logic [35:0] bcd_adj;
  logic [62:0] shifted;
  logic [3:0]  nib;
  logic [3:0]  emit_digit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Add-3 correction on every nibble, then one combined left shift.
  always_comb begin
    bcd_adj = '0;
    nib     = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      nib = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    shifted = {bcd_adj, shreg_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = value;
          ovf_d   = (value > 27'd99_999_999);
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = shifted[62:27];
        shreg_d = shifted[26:0];
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd26) begin
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Display outputs decode from registers only, never from inputs.
  always_comb begin
    emit_digit = bcd_q[{idx_q, 2'b00} +: 4];
    ready = (state_q == IDLE);
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    ovf   = ovf_q;
    dig   = 4'hF;
    pos   = 4'd0;
    if (state_q == EMIT) begin
      pos = {1'b0, idx_q} + 4'd1;
`ifdef SAT_EN
      dig = ovf_q ? 4'd9 : emit_digit;
`else
      dig = emit_digit;
`endif
    end
  end

endmodule

// File: doc/bcd_feeder.md
# bcd_feeder

Sequential binary-to-decimal feeder that sits directly upstream of the 8-digit display controller. It accepts one unsigned 27-bit calculator result per start handshake and converts it to eight BCD digits with an iterative shift-add-3 (double-dabble) engine. It then writes the digits to the display controller as eight consecutive (dig, pos) write cycles.

## Interface
- No parameters. Digit count is fixed at 8 and input width at 27 bits.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  request; sampled only while ready=1.
- value  input  27  unsigned binary result; latched on the accepting edge.
- ready  output  1  1 in IDLE only; reset value 1.
- busy  output  1  1 in CONV, EMIT and DONE; reset value 0.
- done  output  1  1 for exactly one cycle, in the DONE state; reset value 0.
- ovf  output  1  latched flag, 1 when the latched value > 99_999_999; reset value 0.
- dig  output  4  BCD digit to the display controller; 4'hF when not in EMIT; reset value 4'hF.
- pos  output  4  display position 1..8 during EMIT, 0 otherwise; reset value 0.

## Operation
- FSM states: IDLE → CONV → EMIT → DONE → IDLE.
- IDLE, with start=1 at an edge:
  - latch value and compute ovf;
  - clear the 36-bit BCD register (9 digits) and the bit counter;
  - go to CONV.
- IDLE, with start=0: hold.
- CONV, one bit per edge, 27 edges:
  - every BCD nibble ≥ 5 gets +3;
  - then shift {bcd, shreg} left by 1, MSB of value first;
  - on the 27th edge, go to EMIT with index 0.
- EMIT, 8 cycles, index i = 0..7:
  - pos = i+1;
  - dig = BCD digit i, where digit 0 is the units digit. pos k therefore carries the 10^(k-1) digit.
  - after index 7, go to DONE.
- DONE: done=1 and pos=0 for one cycle, then go to IDLE.
- dig and pos decode from state and index registers only, with no combinational path from any input. dig is always < 10 in EMIT, and pos is always 0 outside EMIT, so the downstream controller writes only in EMIT.
- Arithmetic:
  - The BCD register is 9 digits wide, because the maximum value is 134_217_727.
  - Only digits 0..7 are emitted. Digit 8 is used solely for overflow handling; see Configuration.
  - ovf holds until the next accepted start, and the next accepted start re-evaluates it.
- Boundary conditions:
  - start while busy=1 (including in DONE) is ignored; the latched value is unchanged.
  - start held high continuously: a new job is accepted on the first edge of each IDLE cycle, giving one IDLE cycle between jobs.
  - value=0 emits eight zeros.
  - reset asserted in any state takes effect immediately, without waiting for a clock edge:
    - state goes to IDLE;
    - ready=1, busy=0, done=0, ovf=0, pos=0, dig=4'hF;
    - any partial write sequence is abandoned, and positions already written stay written downstream.

## Timing
- E0 is the edge that accepts start.
- CONV performs edges E1..E27.
- EMIT:
  - pos=1 is valid in the cycle after E27, so the downstream controller samples it at E28;
  - pos=8 is valid in the cycle after E34.
- DONE is the cycle after E35.
- ready=1 again after E36.
- Job latency from start acceptance to done is 36 cycles. The minimum start-to-start period is 37 cycles.
- busy rises and ready falls in the cycle after E0.

## Configuration
- SAT_EN defined:
  - when ovf=1, EMIT outputs dig=9 at all eight positions (99999999);
  - when ovf=0, outputs are as normal.
- SAT_EN undefined:
  - EMIT always outputs BCD digits 0..7, so an overflowing value is displayed modulo 10^8;
  - ovf is still computed and reported.
- Timing is identical in both builds.

## Test plan
- value=12_345_678, start pulse:
  - pos 1..8 carry dig 8,7,6,5,4,3,2,1 on consecutive cycles;
  - done=1 exactly 36 cycles after the accepting edge;
  - ovf=0.
- value=0: eight writes of dig=0; pos=0 and dig=4'hF before and after EMIT.
- value=134_217_727:
  - with SAT_EN: all eight digits = 9, ovf=1;
  - without SAT_EN: pos 1..8 carry 7,2,7,7,1,2,4,3, ovf=1.
- value=99_999_999 then value=100_000_000:
  - ovf=0, then ovf=1;
  - ovf holds after the second done until the next start.
- start pulses at E5 and during DONE while busy: ignored; exactly one job's eight writes appear; the latched value is unchanged.
- reset asserted while pos=4:
  - pos=0, dig=4'hF, ready=1, ovf=0 immediately;
  - no done pulse;
  - a subsequent start runs a full 36-cycle job.
